time_keeper: RTL

Time-of-day core of the digital clock, directly downstream of the key debouncers. It consumes single-cycle debounced key pulses for mode and increment, keeps hours/minutes/seconds from a clock-derived 1 Hz prescaler, and runs a three-state set-mode FSM. Its outputs drive the display/segment stage.

---
 rtl/time_keeper.sv | 132 +++++++++++++
 1 files changed

// File: rtl/time_keeper.sv
// Time-of-day core: 1 Hz prescaler, hh:mm:ss carry chain and a RUN/SET_HOUR/SET_MIN edit FSM.
// Optional display blink strobe for the edited field is built when TIME_KEEPER_BLINK_EN is defined.
module time_keeper #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [1:0] mode,
   output logic       sec_tick,
   output logic       blink
);

   localparam int unsigned PW = $clog2(CLK_FREQ);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StSetHour = 2'd1,
      StSetMin  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          run_en, hour_edit, min_edit, resume;
   logic [PW-1:0] presc_q;
   logic          terminal;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun:     if (key_mode) state_d = StSetHour;
         StSetHour: if (key_mode) state_d = StSetMin;
         StSetMin:  if (key_mode) state_d = StRun;
         default:   state_d = StRun;
      endcase
   end

   // key_mode takes priority over key_inc in the edit states.
   always_comb begin
      run_en    = 1'b0;
      hour_edit = 1'b0;
      min_edit  = 1'b0;
      resume    = 1'b0;
      case (state_q)
         StRun:     run_en = 1'b1;
         StSetHour: hour_edit = key_inc & ~key_mode;
         StSetMin: begin
            min_edit = key_inc & ~key_mode;
            resume   = key_mode;
         end
         default: ;
      endcase
   end

   assign mode     = state_q;
   assign terminal = run_en && (presc_q == PRESC_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q  <= '0;
         sec_tick <= 1'b0;
         hour     <= 5'd0;
         minute   <= 6'd0;
         second   <= 6'd0;
      end else begin
         sec_tick <= terminal;
         if (!run_en || terminal) begin
            presc_q <= '0;
         end else begin
            presc_q <= presc_q + PW'(1);
         end

         if (terminal) begin
            if (second == 6'd59) begin
               second <= 6'd0;
               if (minute == 6'd59) begin
                  minute <= 6'd0;
                  hour   <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
               end else begin
                  minute <= minute + 6'd1;
               end
            end else begin
               second <= second + 6'd1;
            end
         end

         if (hour_edit) hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
         if (min_edit) minute <= (minute == 6'd59) ? 6'd0 : minute + 6'd1;
         if (resume) second <= 6'd0;
      end
   end

`ifdef TIME_KEEPER_BLINK_EN
   localparam int unsigned HW = $clog2(CLK_FREQ / 2);
   localparam logic [HW-1:0] HALF_MAX = HW'(CLK_FREQ / 2 - 1);

   logic [HW-1:0] half_q;
   logic          phase_q, phase_d;
   logic          edit_d;

   assign phase_d = (half_q == HALF_MAX) ? ~phase_q : phase_q;
   assign edit_d  = (state_d == StSetHour) || (state_d == StSetMin);

   // Free-running in every mode so the blink cadence never restarts on a mode change.
   always_ff @(posedge clk) begin
      if (rst) begin
         half_q  <= '0;
         phase_q <= 1'b0;
         blink   <= 1'b0;
      end else begin
         half_q  <= (half_q == HALF_MAX) ? '0 : half_q + HW'(1);
         phase_q <= phase_d;
         blink   <= phase_d & edit_d;
      end
   end
`else
   assign blink = 1'b0;
`endif

endmodule
